// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram parser and option loader.
package nonogram_pkg;

  // Parser message flags carried alongside each word
  localparam logic [2:0] FLAG_NONE   = 3'b000;
  localparam logic [2:0] FLAG_OPTION = 3'b010;
  localparam logic [2:0] START_LINE  = 3'b110;
  localparam logic [2:0] END_BOARD   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } load_state_t;

  // A strobed word is a line header only when tagged START_LINE
  function automatic logic is_header(input logic strobe, input logic [2:0] f);
    return strobe && (f == START_LINE);
  endfunction

endpackage

// File: rtl/line_table.sv
// Per-line base address / option count table: one write port, one
// registered read port. Out-of-range reads return zero.
module line_table #(
  parameter int ENTRIES = 22,
  parameter int IW      = 5,
  parameter int AW      = 10,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_base_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [AW-1:0] wr_base,
  input  logic [CW-1:0] wr_count,
  input  logic [IW-1:0] rd_idx,
  output logic [AW-1:0] rd_base,
  output logic [CW-1:0] rd_count
);

  logic [AW-1:0] base_q  [ENTRIES];
  logic [CW-1:0] count_q [ENTRIES];

  // Table storage: cleared on reset, base only rewritten on headers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        base_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else if (wr_en && (int'(wr_idx) < ENTRIES)) begin
      if (wr_base_en) base_q[wr_idx] <= wr_base;
      count_q[wr_idx] <= wr_count;
    end
  end

  // Registered lookup; sees the table contents from before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_base  <= '0;
      rd_count <= '0;
    end else if (int'(rd_idx) < ENTRIES) begin
      rd_base  <= base_q[rd_idx];
      rd_count <= count_q[rd_idx];
    end else begin
      rd_base  <= '0;
      rd_count <= '0;
    end
  end

endmodule

// File: rtl/option_loader.sv
// Loads parser option words into the option BRAM and records, per line,
// where its options start and how many there are.
module option_loader
  import nonogram_pkg::*;
#(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int DEPTH           = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(MAX_ROWS + MAX_COLS),
  localparam int CW = $clog2(MAX_NUM_OPTIONS + 1),
  localparam int MW = $clog2(MAX_ROWS),
  localparam int NW = $clog2(MAX_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_ready,
  input  logic [15:0]   line,
  input  logic [2:0]    flag,
  input  logic          board_done,
  input  logic [MW-1:0] m,
  input  logic [NW-1:0] n,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [15:0]   bram_din,
  input  logic [LW-1:0] lut_idx,
  output logic [AW-1:0] lut_base,
  output logic [CW-1:0] lut_count,
  output logic          load_done,
  output logic [LW:0]   num_lines,
  output logic          busy,
  output logic          err
);

  localparam logic [AW:0] FULL_ADDR = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NUM_OPTIONS);

  load_state_t   state, state_nx;
  logic [AW:0]   wr_addr, wr_addr_nx;     // one extra bit so "full" is visible
  logic [LW-1:0] cur_line, cur_line_nx;
  logic [CW-1:0] cur_count, cur_count_nx; // mirror of count[cur_line]
  logic [LW:0]   num_lines_nx;
  logic          we_nx, done_nx;
  logic [AW-1:0] addr_nx;
  logic [15:0]   din_nx;

  logic          tw_en, tw_base_en;
  logic [LW-1:0] tw_idx;
  logic [AW-1:0] tw_base;
  logic [CW-1:0] tw_count;

  logic          hdr, opt, hdr_bad, full, at_max;
  logic [LW-1:0] hdr_idx;
  logic [LW:0]   span;

  assign hdr     = is_header(write_ready, flag);
  assign opt     = write_ready && !hdr;
  assign hdr_idx = line[LW-1:0];
  assign span    = (LW+1)'(m) + (LW+1)'(n);
  assign hdr_bad = {1'b0, hdr_idx} >= span;
  assign full    = (wr_addr == FULL_ADDR);
  assign at_max  = (cur_count == MAX_CNT);

  assign busy = (state == S_LOAD);
  assign err  = (state == S_ERR);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      cur_line  <= '0;
      cur_count <= '0;
      num_lines <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_addr   <= wr_addr_nx;
      cur_line  <= cur_line_nx;
      cur_count <= cur_count_nx;
      num_lines <= num_lines_nx;
      bram_we   <= we_nx;
      bram_addr <= addr_nx;
      bram_din  <= din_nx;
      load_done <= done_nx;
    end
  end

  // Next-state logic: word handling first, then the board_done transition
  always_comb begin
    state_nx     = state;
    wr_addr_nx   = wr_addr;
    cur_line_nx  = cur_line;
    cur_count_nx = cur_count;
    num_lines_nx = num_lines;
    we_nx        = 1'b0;
    addr_nx      = bram_addr;
    din_nx       = bram_din;
    done_nx      = 1'b0;
    tw_en        = 1'b0;
    tw_base_en   = 1'b0;
    tw_idx       = cur_line;
    tw_base      = wr_addr[AW-1:0];
    tw_count     = cur_count;

    unique case (state)
      S_IDLE, S_DONE: begin
        // A header opens a fresh board; anything else is ignored here
        if (hdr) begin
          if (hdr_bad) begin
            state_nx = S_ERR;
          end else begin
            state_nx     = S_LOAD;
            wr_addr_nx   = '0;
            cur_line_nx  = hdr_idx;
            cur_count_nx = '0;
            num_lines_nx = (LW+1)'(1);
            tw_en        = 1'b1;
            tw_base_en   = 1'b1;
            tw_idx       = hdr_idx;
            tw_base      = '0;
            tw_count     = '0;
          end
        end
      end
      S_LOAD: begin
        if (hdr) begin
          if (hdr_bad) begin
            state_nx = S_ERR;
          end else begin
            cur_line_nx  = hdr_idx;
            cur_count_nx = '0;
            if (!(&num_lines)) num_lines_nx = num_lines + (LW+1)'(1);
            tw_en        = 1'b1;
            tw_base_en   = 1'b1;
            tw_idx       = hdr_idx;
            tw_count     = '0;
          end
        end else if (opt) begin
          if (full || at_max) begin
            state_nx = S_ERR;
          end else begin
            we_nx        = 1'b1;
            addr_nx      = wr_addr[AW-1:0];
            din_nx       = line;
            wr_addr_nx   = wr_addr + (AW+1)'(1);
            cur_count_nx = cur_count + CW'(1);
            tw_en        = 1'b1;
            tw_count     = cur_count + CW'(1);
          end
        end
        if (board_done && (state_nx != S_ERR)) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end
      end
      default: ; // S_ERR holds until reset
    endcase
  end

  line_table #(
    .ENTRIES (MAX_ROWS + MAX_COLS),
    .IW      (LW),
    .AW      (AW),
    .CW      (CW)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (tw_en),
    .wr_base_en (tw_base_en),
    .wr_idx     (tw_idx),
    .wr_base    (tw_base),
    .wr_count   (tw_count),
    .rd_idx     (lut_idx),
    .rd_base    (lut_base),
    .rd_count   (lut_count)
  );

endmodule
